// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings seen on ALU_CONTROL and the
// sequencer state type used by every initiator of the combinational ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MULT = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_ADDV = 4'd4;
    localparam logic [3:0] ALU_SUBV = 4'd5;
    localparam logic [3:0] ALU_XORV = 4'd6;
    localparam logic [3:0] ALU_SLV  = 4'd7;
    localparam logic [3:0] ALU_SRV  = 4'd8;
    localparam logic [3:0] ALU_SCLV = 4'd9;
    localparam logic [3:0] ALU_SCRV = 4'd10;
    // Encodings 11..14 are unassigned; the ALU returns 0 for them.
    localparam logic [3:0] ALU_NOP  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_stream_sequencer.sv
// Streams a job of LEN input words through the external combinational ALU,
// pairing each word with a fixed scalar, and emits registered results.
module alu_stream_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_scalar,
    input  logic [LEN_W-1:0] cmd_len,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,

    output logic [WIDTH-1:0] alu_src_a,
    output logic [WIDTH-1:0] alu_src_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,

    output logic             busy,
    output logic             done
);

    seq_state_t       state;
    seq_state_t       next_state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] scalar_q;
    logic [LEN_W-1:0] count;

    logic cmd_fire;
    logic in_fire;
    logic out_fire;
    logic final_word;

    assign cmd_fire   = cmd_valid && cmd_ready;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign final_word = (count == LEN_W'(1));
    assign busy       = (state != IDLE);

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        next_state  = state;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        alu_src_a   = '0;
        alu_src_b   = '0;
        alu_control = ALU_NOP;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_len != '0)) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                // A held result blocks new input unless it leaves this cycle.
                in_ready    = (count != '0) && (!out_valid || out_ready);
                alu_src_a   = in_data;
                alu_src_b   = scalar_q;
                alu_control = op_q;
                if (in_valid && in_ready && final_word) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && out_last) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= ALU_NOP;
            scalar_q <= '0;
            count    <= '0;
        end else if (cmd_fire) begin
            op_q     <= cmd_op;
            scalar_q <= cmd_scalar;
            count    <= cmd_len;
        end else if (in_fire) begin
            count    <= count - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cmd_fire && (cmd_len == '0)) begin
                done <= 1'b1;
            end
            // An accepted input reloads the register even if the old result
            // is leaving on the same edge, keeping one word per cycle.
            if (in_fire) begin
                out_data  <= alu_out;
                out_valid <= 1'b1;
                out_last  <= final_word;
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                if ((state == DRAIN) && out_last) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_stream_sequencer.sv
// Randomized and directed bench for alu_stream_sequencer with a behavioural
// ALU beside the DUT and a queue-based job model as reference.
module tb_alu_stream_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = ALU_NOP;
    logic [31:0] cmd_scalar = '0;
    logic [7:0]  cmd_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [31:0] alu_src_a;
    logic [31:0] alu_src_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [31:0] words [256];
    res_t        exp_q [$];
    logic [31:0] got_q [$];
    int          pop_cyc [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_stream_sequencer #(.WIDTH(32), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_scalar(cmd_scalar), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    // Behavioural ALU: scalar ops on the full word, vector ops on 4 byte lanes
    // with per-lane shift amounts taken from the low 3 bits of each B lane.
    function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [2:0]  s;
        logic [15:0] t;
        r = '0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_MULT: r = a * b;
            ALU_XOR:  r = a ^ b;
            ALU_XORV: r = a ^ b;
            ALU_ADDV, ALU_SUBV, ALU_SLV, ALU_SRV, ALU_SCLV, ALU_SCRV: begin
                for (int l = 0; l < 4; l++) begin
                    x = a[8*l +: 8];
                    y = b[8*l +: 8];
                    s = y[2:0];
                    t = {x, x};
                    case (op)
                        ALU_ADDV: r[8*l +: 8] = x + y;
                        ALU_SUBV: r[8*l +: 8] = x - y;
                        ALU_SLV:  r[8*l +: 8] = x << s;
                        ALU_SRV:  r[8*l +: 8] = x >> s;
                        ALU_SCLV: begin t = t << s; r[8*l +: 8] = t[15:8]; end
                        default:  begin t = t >> s; r[8*l +: 8] = t[7:0]; end
                    endcase
                end
            end
            default:  r = '0;
        endcase
        return r;
    endfunction

    assign alu_out = alu_ref(alu_control, alu_src_a, alu_src_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_alu_ctrl"}, alu_control, ALU_NOP);
    endtask

    // One job end to end: command, input feed, output drain, DONE. With
    // abort_after >= 0 reset is pulsed once that many words were accepted.
    task automatic run_job(input logic [3:0] op, input logic [31:0] scalar,
                           input int len, input int ready_pct, input int valid_pct,
                           input int stall_first, input int abort_after);
        int   sent;
        int   stall;
        int   budget;
        bit   active;
        bit   finished;
        bit   exp_in_ready;
        res_t r;
        exp_q.delete();
        got_q.delete();
        pop_cyc.delete();
        sent = 0;
        stall = stall_first;
        budget = 0;

        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        check("busy_idle", busy, 0);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_scalar = scalar;
        cmd_len    = len[7:0];
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_op     = 4'($urandom);
        cmd_scalar = $urandom;
        cmd_len    = 8'($urandom);
        active   = (len != 0);
        finished = (len == 0);

        while (!finished) begin
            @(negedge clk);
            if (abort_after >= 0 && sent == abort_after) begin
                #2 rst_n = 1'b0;
                in_valid = 1'b0;
                #1;
                check_reset_values("abort");
                #1 rst_n = 1'b1;
                return;
            end
            check("done_mid", done, 0);
            check("busy", busy, active);
            check("cmd_ready_busy", cmd_ready, 0);
            check("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("out_data", out_data, exp_q[0].data);
                check("out_last", out_last, exp_q[0].last);
            end
            if (stall > 0 && exp_q.size() != 0 && got_q.size() == 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = ($urandom_range(99) < ready_pct);
            end
            in_valid = (sent < len) && ($urandom_range(99) < valid_pct);
            in_data  = in_valid ? words[sent] : $urandom;
            #1;
            exp_in_ready = (sent < len) && (exp_q.size() == 0 || out_ready);
            check("in_ready", in_ready, exp_in_ready);
            check("alu_ctrl", alu_control, (sent < len) ? op : ALU_NOP);
            if (sent < len) begin
                check("alu_src_a", alu_src_a, in_data);
                check("alu_src_b", alu_src_b, scalar);
            end else begin
                check("alu_src_a_drain", alu_src_a, 0);
            end
            if (exp_q.size() != 0 && out_ready) begin
                r = exp_q.pop_front();
                got_q.push_back(out_data);
                pop_cyc.push_back(cyc);
                if (r.last) begin
                    finished = 1'b1;
                    active = 1'b0;
                end
            end
            if (in_valid && exp_in_ready) begin
                exp_q.push_back('{alu_ref(op, words[sent], scalar), sent == len - 1});
                sent++;
            end
            budget++;
            if (budget >= 400) begin
                check("timeout", 0, 1);
                finished = 1'b1;
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        check("done_pulse", done, 1);
        check("out_valid_end", out_valid, 0);
        check("in_ready_end", in_ready, 0);
        check("cmd_ready_end", cmd_ready, 1);
        @(negedge clk);
        check("done_clear", done, 0);
        check("busy_end", busy, 0);
    endtask

    initial begin
        #3;
        check_reset_values("reset");
        #4 rst_n = 1'b1;

        // Byte-lane add with carries confined to each lane.
        words[0] = 32'h01020304; words[1] = 32'h000000FF; words[2] = 32'h7F7F7F7F;
        run_job(ALU_ADDV, 32'h01010101, 3, 100, 100, 0, -1);
        check("addv_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("addv_0", got_q[0], 32'h02030405);
            check("addv_1", got_q[1], 32'h01010100);
            check("addv_2", got_q[2], 32'h80808080);
        end

        // Backpressure on the first result holds it and blocks input.
        words[0] = 32'h0000000A; words[1] = 32'h00000020;
        run_job(ALU_SUB, 32'd5, 2, 100, 100, 4, -1);
        check("sub_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("sub_0", got_q[0], 32'h00000005);
            check("sub_1", got_q[1], 32'h0000001B);
        end

        // Zero-length job completes with only a DONE pulse.
        run_job(ALU_XOR, 32'h12345678, 0, 100, 100, 0, -1);
        check("len0_no_out", got_q.size(), 0);

        // Back-to-back stream at full throughput.
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        run_job(ALU_MULT, 32'd3, 4, 100, 100, 0, -1);
        check("mult_count", got_q.size(), 4);
        for (int i = 0; i < got_q.size(); i++) begin
            check("mult_val", got_q[i], words[i] * 32'd3);
            if (i > 0) check("mult_gap", pop_cyc[i] - pop_cyc[i-1], 1);
        end

        // Reset mid-job, then a fresh single-word job.
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        run_job(ALU_ADD, 32'h00001000, 4, 100, 100, 0, 2);
        @(negedge clk);
        check("post_abort_done", done, 0);
        check("post_abort_valid", out_valid, 0);
        words[0] = 32'h00000042;
        run_job(ALU_ADD, 32'h00001000, 1, 100, 100, 0, -1);
        check("post_abort_count", got_q.size(), 1);
        if (got_q.size() == 1) check("post_abort_val", got_q[0], 32'h00001042);

        // Unassigned opcode passes through and yields zero.
        words[0] = 32'hDEADBEEF;
        run_job(4'b1100, 32'hFFFFFFFF, 1, 100, 100, 0, -1);
        check("unlisted_count", got_q.size(), 1);
        if (got_q.size() == 1) check("unlisted_val", got_q[0], 0);

        // Random jobs under random valid/ready patterns.
        for (int j = 0; j < 30; j++) begin
            int len;
            len = $urandom_range(10);
            for (int i = 0; i < len; i++) words[i] = $urandom;
            run_job(4'($urandom_range(15)), $urandom, len,
                    $urandom_range(30, 100), $urandom_range(30, 100), 0, -1);
            check("rand_count", got_q.size(), len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
